// File: rtl/mem_arbiter_if.sv
// Bundle between the I/D cache miss requesters and the shared-memory arbiter.
// Ports: i/d request+address in, ready pulses, mem_read/mem_addr, grant_id, busy out.
interface mem_arbiter_if #(
   parameter int ADDR_W = 15
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              i_ready;
   logic              d_ready;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_addr;
   logic              grant_id;
   logic              busy;

   modport master (
      output i_req, i_addr, d_req, d_addr,
      input  i_ready, d_ready, mem_read, mem_addr, grant_id, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_addr,
      output i_ready, d_ready, mem_read, mem_addr, grant_id, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving I and D cache misses turns on one main memory.
// Ports: clk, rst (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
   parameter int ADDR_W      = 15,
   parameter int MEM_LATENCY = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              grant;
   logic              grant_nxt;
   logic [ADDR_W-1:0] addr;
   logic              take;

   assign take = (state == IDLE) && (bus.i_req || bus.d_req);

   // Tie goes to whoever was not served last; reset value 1 hands the
   // first tie to I.
   always_comb begin
      grant_nxt = grant;
      unique case (1'b1)
         (bus.i_req && bus.d_req):  grant_nxt = ~grant;
         (bus.i_req && !bus.d_req): grant_nxt = 1'b0;
         (!bus.i_req && bus.d_req): grant_nxt = 1'b1;
         default:                   grant_nxt = grant;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Counter is loaded with LATENCY-1 so BUSY spans LATENCY cycles,
   // leaving the state on the cycle the counter reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         grant <= 1'b1;
         addr  <= '0;
      end else if (take) begin
         cnt   <= LOAD;
         grant <= grant_nxt;
         addr  <= grant_nxt ? bus.d_addr : bus.i_addr;
      end else if (state == BUSY && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (take) state_nxt = BUSY;
         BUSY:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_read = (state != IDLE);
      bus.busy     = (state != IDLE);
      bus.i_ready  = (state == DONE) && !grant;
      bus.d_ready  = (state == DONE) && grant;
      bus.grant_id = grant;
      bus.mem_addr = addr;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector tables, corner sequences, random vs model.
// Ports: none (instantiates mem_arbiter_if and mem_arbiter).
module tb_mem_arbiter;
   localparam int AW = 15;
   localparam int L  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW)) bus();

   mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic          ir;
      logic          dr;
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      logic [19:0]   exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [19:0] outs();
      return {bus.mem_read, bus.i_ready, bus.d_ready, bus.busy,
              bus.grant_id, bus.mem_addr};
   endfunction

   function automatic logic [19:0] ex(logic mr, logic ir, logic dr,
                                      logic b, logic g, logic [AW-1:0] ma);
      return {mr, ir, dr, b, g, ma};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive(logic ir, logic dr, logic [AW-1:0] ia, logic [AW-1:0] da);
      bus.i_req  = ir;
      bus.d_req  = dr;
      bus.i_addr = ia;
      bus.d_addr = da;
   endtask

   task automatic push(logic ir, logic dr, logic [AW-1:0] ia, logic [AW-1:0] da,
                       logic [19:0] e);
      vec_t v;
      v.ir = ir; v.dr = dr; v.ia = ia; v.da = da; v.exp = e;
      tbl.push_back(v);
   endtask

   // Ends at a negedge with rst just released: that cycle is cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 1'b1, AW'($urandom), AW'($urandom));
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("reset", 32'(outs()), 32'(ex(0, 0, 0, 0, 1, '0)));
         @(negedge clk);
      end
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
   endtask

   task automatic run_tbl(string nm);
      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].ir, tbl[k].dr, tbl[k].ia, tbl[k].da);
         #1;
         chk($sformatf("%s c%0d", nm, k), 32'(outs()), 32'(tbl[k].exp));
         @(negedge clk);
      end
      tbl.delete();
   endtask

   task automatic test_single_and_tie();
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      ia = 15'h0123;
      da = 15'h7FF0;
      push(1, 1, ia, da, ex(0, 0, 0, 0, 1, '0));
      for (int k = 1; k <= 4; k++) push(1, 1, ia, da, ex(1, 0, 0, 1, 0, ia));
      push(1, 1, ia, da, ex(1, 1, 0, 1, 0, ia));
      push(0, 1, ia, da, ex(0, 0, 0, 0, 0, ia));
      for (int k = 7; k <= 10; k++) push(0, 1, ia, da, ex(1, 0, 0, 1, 1, da));
      push(0, 1, ia, da, ex(1, 0, 1, 1, 1, da));
      push(0, 0, ia, da, ex(0, 0, 0, 0, 1, da));
      push(0, 0, ia, da, ex(0, 0, 0, 0, 1, da));
      do_reset();
      run_tbl("tie");
   endtask

   task automatic test_drop_and_addr_change();
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      a0 = 15'h0AAA;
      a1 = 15'h1555;
      push(1, 0, a0, a1, ex(0, 0, 0, 0, 1, '0));
      push(1, 0, a0, a1, ex(1, 0, 0, 1, 0, a0));
      push(0, 0, a0, a1, ex(1, 0, 0, 1, 0, a0));
      push(0, 0, a1, a0, ex(1, 0, 0, 1, 0, a0));
      push(0, 0, a1, a0, ex(1, 0, 0, 1, 0, a0));
      push(0, 0, a1, a0, ex(1, 1, 0, 1, 0, a0));
      for (int k = 6; k <= 8; k++) push(0, 0, a1, a0, ex(0, 0, 0, 0, 0, a0));
      do_reset();
      run_tbl("drop");
   endtask

   task automatic test_reset_mid();
      int lat;
      do_reset();
      drive(1, 0, 15'h0123, 15'h0456);
      #1;
      @(negedge clk);
      for (int k = 1; k <= 3; k++) begin
         #1;
         chk($sformatf("rmid busy c%0d", k), 32'(outs()),
             32'(ex(1, 0, 0, 1, 0, 15'h0123)));
         @(negedge clk);
      end
      // Mid cycle 4 of the transaction, pull reset.
      rst = 1'b0;
      #1;
      chk("rmid abort", 32'(outs()), 32'(ex(0, 0, 0, 0, 1, '0)));
      @(negedge clk);
      #1;
      chk("rmid hold", 32'(outs()), 32'(ex(0, 0, 0, 0, 1, '0)));
      rst = 1'b1;
      lat = -1;
      for (int n = 0; n < 16 && lat < 0; n++) begin
         if (bus.i_ready) lat = n;
         else begin
            @(negedge clk);
            #1;
         end
      end
      chk("rmid latency", 32'(lat), 32'(L + 1));
      @(negedge clk);
      drive(0, 0, '0, '0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_round_robin();
      int   g;
      logic pb;
      do_reset();
      drive(1, 1, 15'h0111, 15'h0222);
      g  = 0;
      pb = 1'b0;
      for (int c = 0; c < 80 && g < 6; c++) begin
         #1;
         chk("rr overlap", 32'(bus.i_ready & bus.d_ready), 32'(0));
         if (bus.busy && !pb) begin
            chk($sformatf("rr grant %0d", g), 32'(bus.grant_id), 32'(g % 2));
            g++;
         end
         pb = bus.busy;
         @(negedge clk);
      end
      chk("rr count", 32'(g), 32'(6));
      drive(0, 0, '0, '0);
      repeat (8) @(negedge clk);
   endtask

   // Transaction-level model: a grant taken in idle cycle gc occupies
   // cycles gc+1 .. gc+L+1, with the ready pulse in the last of them.
   task automatic test_random();
      int            gc;
      logic          last;
      logic [AW-1:0] la;
      logic          pri;
      logic          prd;
      logic          ir;
      logic          dr;
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      logic          in_txn;
      logic          done;
      logic          w;
      do_reset();
      gc   = -1000;
      last = 1'b1;
      la   = '0;
      pri  = 1'b0;
      prd  = 1'b0;
      for (int c = 0; c < 400; c++) begin
         ir = pri ? 1'b0 : ($urandom_range(0, 2) != 0);
         dr = prd ? 1'b0 : ($urandom_range(0, 2) != 0);
         ia = AW'($urandom);
         da = AW'($urandom);
         drive(ir, dr, ia, da);
         #1;
         in_txn = (c > gc) && (c <= gc + L + 1);
         done   = (c == gc + L + 1);
         chk($sformatf("rand c%0d", c), 32'(outs()),
             32'(ex(in_txn, done && !last, done && last, in_txn, last, la)));
         pri = done && !last;
         prd = done && last;
         if (!in_txn && (ir || dr)) begin
            w    = (ir && dr) ? !last : dr;
            gc   = c;
            last = w;
            la   = w ? da : ia;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      drive(0, 0, '0, '0);
      test_single_and_tie();
      test_drop_and_addr_change();
      test_reset_mid();
      test_round_robin();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
